// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared state encoding, stream header size and image-size limit for the loader
package prog_loader_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR
  } state_t;
  localparam int HDR_BYTES = 2;
  localparam int LEN_W = 8 * HDR_BYTES;
  function automatic logic [63:0] max_words(input int addr_w);
    return 64'(1) << addr_w;
  endfunction
endpackage

// File: rtl/prog_loader_byte_assembler.sv
// prog_loader_byte_assembler: shifts stream bytes MSB-first into a memory word
//  i_clk, i_rst_n : clock, async active-low reset
//  i_clear        : drop any partial word
//  i_load, i_data : shift one byte in
//  o_word         : assembled word (complete in the cycle after o_word_full)
//  o_word_full    : this load supplies the last byte of the word
module prog_loader_byte_assembler #(
  parameter int WORD_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  input  logic              i_load,
  input  logic [7:0]        i_data,
  output logic [WORD_W-1:0] o_word,
  output logic              o_word_full
);
  localparam int BPW = WORD_W / 8;
  localparam int CW = $clog2(BPW) + 1;
  logic [CW-1:0]     r_cnt;
  logic [WORD_W-1:0] r_word;
  assign o_word = r_word;
  assign o_word_full = i_load && (r_cnt == CW'(BPW - 1));
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_word <= '0;
    end else if (i_clear) begin
      r_cnt  <= '0;
      r_word <= '0;
    end else if (i_load) begin
      r_word <= (r_word << 8) | WORD_W'(i_data);
      r_cnt  <= o_word_full ? '0 : r_cnt + CW'(1);
    end
  end
endmodule

// File: rtl/prog_loader.sv
// prog_loader: boot loader turning a length-prefixed byte stream into memory word writes
//  Optional trailing XOR checksum byte enabled by defining PROG_LOADER_CSUM_EN.
//  i_clk, i_rst_n          : clock, async active-low reset
//  i_start                 : begin a load (honoured in IDLE/DONE/ERR)
//  i_in_valid, i_in_data   : byte stream in; o_in_ready accepts it
//  o_mem_we/addr/wdata     : one-cycle word write, address/data held afterwards
//  o_cpu_rst, o_done, o_error : CPU reset (released only in DONE), status levels
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int WORD_W = 16,
  parameter int ADDR_W = 12
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_in_valid,
  input  logic [7:0]        i_in_data,
  output logic              o_in_ready,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [WORD_W-1:0] o_mem_wdata,
  output logic              o_cpu_rst,
  output logic              o_done,
  output logic              o_error
);
`ifdef PROG_LOADER_CSUM_EN
  localparam state_t S_TAIL = S_CSUM;
`else
  localparam state_t S_TAIL = S_DONE;
`endif
  state_t            r_state, w_next;
  logic [LEN_W-1:0]  r_len, r_widx, w_len;
  logic [ADDR_W-1:0] r_addr;
  logic [WORD_W-1:0] r_wdata, w_word;
  logic              w_xfer, w_start, w_full, w_last, w_oversize;
`ifdef PROG_LOADER_CSUM_EN
  logic [7:0]        r_csum;
`endif
  assign w_xfer = i_in_valid && o_in_ready;
  assign w_start = i_start && (r_state inside {S_IDLE, S_DONE, S_ERR});
  assign w_len = {r_len[LEN_W-1:8], i_in_data};
  assign w_oversize = 64'(w_len) > max_words(ADDR_W);
  assign w_last = (r_widx + LEN_W'(1)) == r_len;
  prog_loader_byte_assembler #(.WORD_W(WORD_W)) u_asm (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clear    (w_start),
    .i_load     (w_xfer && r_state == S_DATA),
    .i_data     (i_in_data),
    .o_word     (w_word),
    .o_word_full(w_full)
  );
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: if (w_start) w_next = S_LEN_HI;
      S_LEN_HI: if (w_xfer) w_next = S_LEN_LO;
      S_LEN_LO: if (w_xfer) w_next = (w_len == '0) ? S_TAIL : w_oversize ? S_ERR : S_DATA;
      S_DATA:   if (w_full) w_next = S_WRITE;
      S_WRITE:  w_next = w_last ? S_TAIL : S_DATA;
`ifdef PROG_LOADER_CSUM_EN
      S_CSUM:   if (w_xfer) w_next = (i_in_data == r_csum) ? S_DONE : S_ERR;
`endif
      default:  w_next = S_IDLE;
    endcase
  end
  always_comb begin
    o_in_ready  = r_state inside {S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM};
    o_mem_we    = r_state == S_WRITE;
    o_mem_addr  = (r_state == S_WRITE) ? ADDR_W'(r_widx) : r_addr;
    o_mem_wdata = (r_state == S_WRITE) ? w_word : r_wdata;
    o_cpu_rst   = r_state != S_DONE;
    o_done      = r_state == S_DONE;
    o_error     = r_state == S_ERR;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_len   <= '0;
      r_widx  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_start) begin
      r_len  <= '0;
      r_widx <= '0;
    end else begin
      if (w_xfer && r_state == S_LEN_HI) r_len[LEN_W-1:8] <= i_in_data;
      if (w_xfer && r_state == S_LEN_LO) r_len[7:0] <= i_in_data;
      if (r_state == S_WRITE) begin
        r_widx  <= r_widx + LEN_W'(1);
        r_addr  <= ADDR_W'(r_widx);
        r_wdata <= w_word;
      end
    end
  end
`ifdef PROG_LOADER_CSUM_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_csum <= '0;
    else if (w_start) r_csum <= '0;
    else if (w_xfer && r_state != S_CSUM) r_csum <= r_csum ^ i_in_data;
  end
`endif
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized load scenarios checked against a byte-stream reference model
module tb_prog_loader;
  localparam int WORD_W = 16;
  localparam int ADDR_W = 4;
  localparam int MAXW = 1 << ADDR_W;
`ifdef PROG_LOADER_CSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif
  logic              i_clk = 1'b0;
  logic              i_rst_n = 1'b0;
  logic              i_start = 1'b0;
  logic              i_in_valid = 1'b0;
  logic [7:0]        i_in_data = 8'h00;
  logic              o_in_ready, o_mem_we, o_cpu_rst, o_done, o_error;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [WORD_W-1:0] o_mem_wdata;
  int n_checks = 0;
  int n_fail = 0;
  logic [15:0]       img[$];
  logic [ADDR_W-1:0] wr_addr[$];
  logic [15:0]       wr_data[$];

  prog_loader #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start),
    .i_in_valid(i_in_valid), .i_in_data(i_in_data), .o_in_ready(o_in_ready),
    .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .o_cpu_rst(o_cpu_rst), .o_done(o_done), .o_error(o_error)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) if (o_mem_we) begin
    wr_addr.push_back(o_mem_addr);
    wr_data.push_back(o_mem_wdata);
  end

  task automatic fill(input int n);
    img.delete();
    repeat (n) img.push_back(16'($urandom));
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps, input bit pulse_start);
    bit r;
    if (gaps && $urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge i_clk);
    i_in_valid = 1'b1;
    i_in_data = b;
    i_start = pulse_start;
    for (int t = 0; ; t++) begin
      r = o_in_ready;
      @(posedge i_clk);
      @(negedge i_clk);
      i_start = 1'b0;
      if (r) break;
      if (t > 50) begin
        n_checks++;
        n_fail++;
        $display("FAIL byte_accept timeout: in_ready stayed 0, required 1");
        break;
      end
    end
    i_in_valid = 1'b0;
  endtask

  task automatic run_load(input int n, input bit gaps, input bit mid, input bit bad);
    logic [7:0] s[$];
    logic [7:0] cs;
    bit ok;
    int exp_n;
    exp_n = (n <= MAXW) ? n : 0;
    ok = (n <= MAXW) && !(CSUM && bad);
    s.push_back(8'(n >> 8));
    s.push_back(8'(n));
    for (int w = 0; w < exp_n; w++) begin
      s.push_back(img[w][15:8]);
      s.push_back(img[w][7:0]);
    end
    cs = 8'h00;
    foreach (s[i]) cs ^= s[i];
    if (CSUM && n <= MAXW) s.push_back(cs ^ {7'b0, bad});
    wr_addr.delete();
    wr_data.delete();
    @(negedge i_clk) i_start = 1'b1;
    @(negedge i_clk) i_start = 1'b0;
    n_checks++;
    if ({o_in_ready, o_error, o_done, o_cpu_rst} !== 4'b1001) begin
      n_fail++;
      $display("FAIL start_accept: ready/err/done/cpu_rst=%b required 1001", {o_in_ready, o_error, o_done, o_cpu_rst});
    end
    foreach (s[i]) begin
      send_byte(s[i], gaps, mid && i == 3);
      if (i == 1 && n > MAXW) begin
        n_checks++;
        if ({o_error, o_in_ready, o_mem_we} !== 3'b100) begin
          n_fail++;
          $display("FAIL oversize_err: err/ready/we=%b required 100", {o_error, o_in_ready, o_mem_we});
        end
      end
      if (i >= 2 && i < 2 + 2 * exp_n && (i - 2) % 2 == 1) begin
        n_checks++;
        if (o_mem_we !== 1'b1) begin
          n_fail++;
          $display("FAIL write_latency: byte %0d mem_we=%b required 1", i, o_mem_we);
        end
      end
    end
    for (int t = 0; t < 20 && !(o_done || o_error); t++) @(negedge i_clk);
    repeat (2) @(negedge i_clk);
    n_checks++;
    if (wr_data.size() != exp_n) begin
      n_fail++;
      $display("FAIL write_count: n=%0d got %0d writes required %0d", n, wr_data.size(), exp_n);
    end
    for (int k = 0; k < exp_n && k < wr_data.size(); k++) begin
      n_checks++;
      if (wr_addr[k] !== ADDR_W'(k) || wr_data[k] !== img[k]) begin
        n_fail++;
        $display("FAIL write_%0d: addr=%h data=%h required addr=%h data=%h", k, wr_addr[k], wr_data[k], ADDR_W'(k), img[k]);
      end
    end
    n_checks++;
    if ({o_done, o_error, o_cpu_rst, o_in_ready} !== {ok, !ok, !ok, 1'b0}) begin
      n_fail++;
      $display("FAIL final_status n=%0d: done/err/cpu_rst/ready=%b required %b", n, {o_done, o_error, o_cpu_rst, o_in_ready}, {ok, !ok, !ok, 1'b0});
    end
    if (exp_n > 0) begin
      n_checks++;
      if (o_mem_addr !== ADDR_W'(exp_n - 1) || o_mem_wdata !== img[exp_n-1]) begin
        n_fail++;
        $display("FAIL hold_last: addr=%h data=%h required addr=%h data=%h", o_mem_addr, o_mem_wdata, ADDR_W'(exp_n - 1), img[exp_n-1]);
      end
    end
  endtask

  task automatic test_reset;
    #12;
    n_checks++;
    if ({o_in_ready, o_mem_we, o_cpu_rst, o_done, o_error} !== 5'b00100 || o_mem_addr !== '0 || o_mem_wdata !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: flags=%b addr=%h data=%h required 00100/0/0", {o_in_ready, o_mem_we, o_cpu_rst, o_done, o_error}, o_mem_addr, o_mem_wdata);
    end
    @(negedge i_clk) i_rst_n = 1'b1;
    repeat (3) @(negedge i_clk);
    n_checks++;
    if ({o_in_ready, o_cpu_rst, o_done} !== 3'b010) begin
      n_fail++;
      $display("FAIL idle_hold: ready/cpu_rst/done=%b required 010", {o_in_ready, o_cpu_rst, o_done});
    end
  endtask

  task automatic test_basic;
    img.delete();
    img.push_back(16'h1234);
    img.push_back(16'hABCD);
    run_load(2, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_bad_csum;
    run_load(2, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_zero_len;
    img.delete();
    run_load(0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_oversize;
    img.delete();
    run_load(17, 1'b0, 1'b0, 1'b0);
    run_load(16'h1234, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_max;
    fill(MAXW);
    run_load(MAXW, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_random;
    repeat (6) begin
      int n;
      n = $urandom_range(1, MAXW);
      fill(n);
      run_load(n, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  task automatic test_reset_mid;
    fill(3);
    wr_addr.delete();
    wr_data.delete();
    @(negedge i_clk) i_start = 1'b1;
    @(negedge i_clk) i_start = 1'b0;
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'h03, 1'b0, 1'b0);
    send_byte(img[0][15:8], 1'b0, 1'b0);
    #2 i_rst_n = 1'b0;
    #1;
    n_checks++;
    if ({o_in_ready, o_mem_we, o_cpu_rst, o_done, o_error} !== 5'b00100 || o_mem_addr !== '0 || o_mem_wdata !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: flags=%b addr=%h data=%h required 00100/0/0", {o_in_ready, o_mem_we, o_cpu_rst, o_done, o_error}, o_mem_addr, o_mem_wdata);
    end
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (2) @(negedge i_clk);
    n_checks++;
    if (wr_data.size() != 0) begin
      n_fail++;
      $display("FAIL reset_mid_writes: got %0d writes required 0", wr_data.size());
    end
    run_load(3, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_bad_csum;
    test_zero_len;
    test_oversize;
    test_max;
    test_random;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
